// File: rtl/haz_issue_sched.sv
// Issue-side scheduler: derives hazard classes for the hazard-resolver FSM from a
// small destination scoreboard and a single unresolved-branch tracker.
module haz_issue_sched #(
  parameter int unsigned RAW    = 5,
  parameter int unsigned BR_TMO = 15,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  output logic             id_ready,
  input  logic [RAW-1:0]   id_rs1,
  input  logic [RAW-1:0]   id_rs2,
  input  logic [RAW-1:0]   id_rd,
  input  logic             id_rd_we,
  input  logic             id_is_load,
  input  logic             id_is_mem,
  input  logic             id_is_br,
  input  logic             id_pred_tk,
  input  logic             mem_busy,
  input  logic             ex_br_valid,
  input  logic             ex_br_taken,
  input  logic             pc_freeze,
  input  logic             do_flush,
  output logic             data,
  output logic             fwrd,
  output logic             str,
  output logic             ctrl,
  output logic             branch,
  output logic             crct,
  output logic [7:0]       flush_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             br_err
);

  localparam int unsigned TW = $clog2(BR_TMO + 1);

  typedef enum logic {BR_IDLE, BR_PEND} br_state_t;

  typedef struct packed {
    logic           v;
    logic [RAW-1:0] rd;
    logic           ld;
  } slot_t;

  // The WB slot is bypassed through the register file and can never raise a
  // hazard, so only EX and MEM are held as state.
  slot_t     r_ex, r_mem;
  br_state_t r_state, w_state_nxt;
  logic [TW-1:0] r_timer;
  logic      r_pred;
  logic      w_m_ex, w_m_mem, w_accept, w_err_set;

  always_comb begin
    w_m_ex  = id_valid && r_ex.v && (r_ex.rd != '0) &&
              ((r_ex.rd == id_rs1) || (r_ex.rd == id_rs2));
    w_m_mem = id_valid && r_mem.v && (r_mem.rd != '0) &&
              ((r_mem.rd == id_rs1) || (r_mem.rd == id_rs2));
    data     = w_m_ex || w_m_mem;
    fwrd     = data && !(w_m_ex && r_ex.ld);
    str      = id_valid && id_is_mem && mem_busy;
    id_ready = !pc_freeze && !do_flush && !(data && !fwrd) && !str &&
               (r_state != BR_PEND);
    w_accept = id_valid && id_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex  <= '0;
      r_mem <= '0;
    end else begin
      r_mem <= r_ex;
      if (w_accept) begin
        r_ex.v  <= id_rd_we && (id_rd != '0);
        r_ex.rd <= id_rd;
        r_ex.ld <= id_is_load;
      end else begin
        r_ex <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= BR_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    ctrl        = 1'b0;
    branch      = 1'b0;
    crct        = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      BR_IDLE: begin
        if (ex_br_valid) w_err_set = 1'b1;
        if (w_accept && id_is_br) w_state_nxt = BR_PEND;
      end
      BR_PEND: begin
        ctrl = 1'b1;
        if (ex_br_valid) begin
          branch      = 1'b1;
          crct        = (ex_br_taken == r_pred);
          w_state_nxt = BR_IDLE;
        end else if (r_timer == TW'(BR_TMO - 1)) begin
          w_err_set = 1'b1;
        end
      end
      default: w_state_nxt = BR_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= '0;
      r_pred  <= 1'b0;
      br_err  <= 1'b0;
    end else begin
      if (w_err_set) br_err <= 1'b1;
      if ((r_state == BR_IDLE) && w_accept && id_is_br) begin
        r_timer <= '0;
        r_pred  <= id_pred_tk;
      end else if ((r_state == BR_PEND) && (r_timer != TW'(BR_TMO))) begin
        r_timer <= r_timer + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (do_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
      if (id_valid && !id_ready && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_haz_issue_sched.sv
// Bench for haz_issue_sched: directed scenarios plus randomized traffic checked
// against an issue-log reference model.
module tb_haz_issue_sched;

  localparam int unsigned BR_TMO = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic id_valid, id_ready, id_rd_we, id_is_load, id_is_mem, id_is_br, id_pred_tk;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic mem_busy, ex_br_valid, ex_br_taken, pc_freeze, do_flush;
  logic data, fwrd, str, ctrl, branch, crct, br_err;
  logic [7:0] flush_cnt;
  logic [15:0] stall_cnt;

  int nchk = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  haz_issue_sched #(.RAW(5), .BR_TMO(BR_TMO), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_rd_we(id_rd_we),
    .id_is_load(id_is_load), .id_is_mem(id_is_mem), .id_is_br(id_is_br),
    .id_pred_tk(id_pred_tk), .mem_busy(mem_busy), .ex_br_valid(ex_br_valid),
    .ex_br_taken(ex_br_taken), .pc_freeze(pc_freeze), .do_flush(do_flush),
    .data(data), .fwrd(fwrd), .str(str), .ctrl(ctrl), .branch(branch), .crct(crct),
    .flush_cnt(flush_cnt), .stall_cnt(stall_cnt), .br_err(br_err)
  );

  // Reference model: a log of accepted instructions stamped with their issue cycle.
  typedef struct {
    int unsigned cyc;
    bit          v;
    bit [4:0]    rd;
    bit          ld;
  } rec_t;
  rec_t log_q[$];
  int unsigned cyc;
  bit m_pend, m_pred, m_err;
  int unsigned m_since, m_flush, m_stall;
  bit e_data, e_fwrd, e_str, e_ctrl, e_branch, e_crct, e_ready;

  task automatic model_reset();
    log_q.delete();
    cyc = 0; m_pend = 0; m_pred = 0; m_err = 0; m_since = 0; m_flush = 0; m_stall = 0;
  endtask

  task automatic model_eval();
    bit hit, exld;
    hit = 0; exld = 0;
    foreach (log_q[i]) begin
      int unsigned age;
      age = cyc - log_q[i].cyc;
      if ((age == 1 || age == 2) && log_q[i].v && log_q[i].rd != 0 &&
          (log_q[i].rd == id_rs1 || log_q[i].rd == id_rs2)) begin
        hit = 1;
        if (age == 1 && log_q[i].ld) exld = 1;
      end
    end
    e_data   = id_valid && hit;
    e_fwrd   = e_data && !exld;
    e_str    = id_valid && id_is_mem && mem_busy;
    e_ctrl   = m_pend;
    e_branch = m_pend && ex_br_valid;
    e_crct   = e_branch && (ex_br_taken == m_pred);
    e_ready  = !pc_freeze && !do_flush && !(e_data && !e_fwrd) && !e_str && !m_pend;
  endtask

  task automatic model_step();
    bit acc;
    model_eval();
    acc = id_valid && e_ready;
    if (acc) log_q.push_back('{cyc, id_rd_we && id_rd != 0, id_rd, id_is_load});
    if (id_valid && !e_ready && m_stall < 65535) m_stall++;
    if (do_flush && m_flush < 255) m_flush++;
    if (m_pend) begin
      if (ex_br_valid) m_pend = 0;
      else if (cyc + 1 - m_since >= BR_TMO) m_err = 1;
    end else begin
      if (ex_br_valid) m_err = 1;
      if (acc && id_is_br) begin
        m_pend = 1; m_pred = id_pred_tk; m_since = cyc + 1;
      end
    end
    cyc++;
    while (log_q.size() > 0 && cyc - log_q[0].cyc > 2) void'(log_q.pop_front());
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_rd_we = 0; id_is_load = 0;
    id_is_mem = 0; id_is_br = 0; id_pred_tk = 0; mem_busy = 0; ex_br_valid = 0;
    ex_br_taken = 0; pc_freeze = 0; do_flush = 0;
  endtask

  task automatic offer(input bit [4:0] rs1, input bit [4:0] rs2, input bit [4:0] rd,
                       input bit we, input bit ld, input bit mem, input bit br, input bit pt);
    id_valid = 1; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_rd_we = we;
    id_is_load = ld; id_is_mem = mem; id_is_br = br; id_pred_tk = pt;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge clk);
    rst_n = 0;
    #2;
    model_reset();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    do_flush = 1;
    tick(); tick();
    idle_inputs();
    offer(0, 0, 0, 0, 0, 0, 1, 1);
    tick();
    idle_inputs();
    #1;
    nchk++; if (ctrl !== 1'b1) begin nfail++; $display("FAIL pre_reset_ctrl got=%0b exp=1", ctrl); end
    #2;
    rst_n = 0;
    #1;
    nchk++;
    if ({data, fwrd, str, ctrl, branch, crct, br_err} !== 7'b0 || flush_cnt !== 8'd0 || stall_cnt !== 16'd0) begin
      nfail++;
      $display("FAIL reset_outputs got=%b flush=%0d stall=%0d exp=all zero",
               {data, fwrd, str, ctrl, branch, crct, br_err}, flush_cnt, stall_cnt);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    offer(1, 2, 3, 1, 0, 0, 0, 0);
    #1;
    nchk++; if (id_ready !== 1'b1) begin nfail++; $display("FAIL reset_ready got=%0b exp=1", id_ready); end
    idle_inputs();
  endtask

  task automatic test_load_use();
    do_reset();
    offer(0, 0, 5, 1, 1, 0, 0, 0);
    #1;
    nchk++; if (id_ready !== 1'b1) begin nfail++; $display("FAIL load_accept got=%0b exp=1", id_ready); end
    tick();
    offer(5, 0, 1, 1, 0, 0, 0, 0);
    #1;
    nchk++;
    if ({data, fwrd, id_ready} !== 3'b100) begin
      nfail++; $display("FAIL load_use_ex got data,fwrd,ready=%b exp=100", {data, fwrd, id_ready});
    end
    tick();
    #1;
    nchk++;
    if ({data, fwrd, id_ready} !== 3'b111) begin
      nfail++; $display("FAIL load_use_mem got data,fwrd,ready=%b exp=111", {data, fwrd, id_ready});
    end
    tick();
    idle_inputs();
    #1;
    nchk++; if (stall_cnt !== 16'd1) begin nfail++; $display("FAIL load_use_stall got=%0d exp=1", stall_cnt); end
  endtask

  task automatic test_alu_fwd();
    do_reset();
    offer(0, 0, 3, 1, 0, 0, 0, 0);
    tick();
    offer(6, 3, 8, 1, 0, 0, 0, 0);
    #1;
    nchk++;
    if ({data, fwrd, id_ready} !== 3'b111) begin
      nfail++; $display("FAIL alu_fwd got data,fwrd,ready=%b exp=111", {data, fwrd, id_ready});
    end
    tick();
    offer(0, 0, 0, 1, 1, 0, 0, 0);
    tick();
    offer(0, 0, 7, 0, 0, 0, 0, 0);
    tick();
    offer(0, 7, 2, 1, 0, 0, 0, 0);
    #1;
    nchk++;
    if ({data, fwrd} !== 2'b00) begin
      nfail++; $display("FAIL rd0_or_nowe got data,fwrd=%b exp=00", {data, fwrd});
    end
    tick();
    offer(0, 0, 9, 1, 0, 0, 0, 0);
    tick();
    idle_inputs();
    tick(); tick();
    offer(9, 0, 1, 1, 0, 0, 0, 0);
    #1;
    nchk++; if (data !== 1'b0) begin nfail++; $display("FAIL wb_bypass got data=%0b exp=0", data); end
    idle_inputs();
  endtask

  task automatic test_branch();
    do_reset();
    offer(0, 0, 0, 0, 0, 0, 1, 1);
    tick();
    idle_inputs();
    for (int unsigned k = 0; k < 3; k++) begin
      #1;
      nchk++;
      if ({ctrl, branch} !== 2'b10) begin
        nfail++; $display("FAIL br_pend cycle %0d got ctrl,branch=%b exp=10", k, {ctrl, branch});
      end
      if (k < 2) tick();
    end
    ex_br_valid = 1; ex_br_taken = 0;
    offer(1, 1, 1, 1, 0, 0, 0, 0);
    #1;
    nchk++;
    if ({branch, crct, id_ready} !== 3'b100) begin
      nfail++; $display("FAIL br_resolve got branch,crct,ready=%b exp=100", {branch, crct, id_ready});
    end
    tick();
    idle_inputs();
    do_flush = 1;
    #1;
    nchk++;
    if ({ctrl, branch} !== 2'b00) begin
      nfail++; $display("FAIL br_after got ctrl,branch=%b exp=00", {ctrl, branch});
    end
    tick();
    idle_inputs();
    offer(0, 0, 0, 0, 0, 0, 1, 0);
    #1;
    nchk++;
    if (flush_cnt !== 8'd1 || id_ready !== 1'b1) begin
      nfail++; $display("FAIL flush_one got flush=%0d ready=%0b exp=1,1", flush_cnt, id_ready);
    end
    tick();
    idle_inputs();
    ex_br_valid = 1; ex_br_taken = 0;
    #1;
    nchk++;
    if ({branch, crct, br_err} !== 3'b110) begin
      nfail++; $display("FAIL br_correct got branch,crct,err=%b exp=110", {branch, crct, br_err});
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_struct();
    do_reset();
    offer(0, 0, 0, 0, 0, 1, 0, 0);
    mem_busy = 1;
    for (int unsigned k = 0; k < 4; k++) begin
      #1;
      nchk++;
      if ({str, id_ready} !== 2'b10) begin
        nfail++; $display("FAIL str_busy cycle %0d got str,ready=%b exp=10", k, {str, id_ready});
      end
      tick();
    end
    mem_busy = 0;
    #1;
    nchk++;
    if (stall_cnt !== 16'd4 || id_ready !== 1'b1) begin
      nfail++; $display("FAIL str_stall got stall=%0d ready=%0b exp=4,1", stall_cnt, id_ready);
    end
    offer(0, 0, 4, 1, 1, 0, 0, 0);
    tick();
    offer(4, 0, 0, 0, 0, 1, 0, 0);
    mem_busy = 1;
    #1;
    nchk++;
    if ({data, fwrd, str, id_ready} !== 4'b1010) begin
      nfail++; $display("FAIL data_and_str got data,fwrd,str,ready=%b exp=1010", {data, fwrd, str, id_ready});
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_timeout();
    do_reset();
    offer(0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    idle_inputs();
    for (int unsigned k = 1; k <= 16; k++) begin
      tick();
      if (k == 10) begin
        nchk++; if (br_err !== 1'b0) begin nfail++; $display("FAIL tmo_early got=%0b exp=0", br_err); end
      end
    end
    nchk++; if (br_err !== 1'b1 || ctrl !== 1'b1) begin
      nfail++; $display("FAIL tmo_set got err=%0b ctrl=%0b exp=1,1", br_err, ctrl);
    end
    ex_br_valid = 1;
    tick();
    idle_inputs();
    tick();
    nchk++; if (br_err !== 1'b1) begin nfail++; $display("FAIL tmo_sticky got=%0b exp=1", br_err); end
    do_reset();
    ex_br_valid = 1;
    tick();
    idle_inputs();
    nchk++; if (br_err !== 1'b1) begin nfail++; $display("FAIL stray_resolve got=%0b exp=1", br_err); end
  endtask

  task automatic test_flush_sat();
    do_reset();
    do_flush = 1;
    for (int unsigned k = 0; k < 300; k++) tick();
    idle_inputs();
    nchk++; if (flush_cnt !== 8'd255) begin nfail++; $display("FAIL flush_sat got=%0d exp=255", flush_cnt); end
  endtask

  task automatic test_random();
    do_reset();
    for (int unsigned k = 0; k < 3000; k++) begin
      id_valid    = ($urandom_range(3) != 0);
      id_rs1      = 5'($urandom_range(7));
      id_rs2      = 5'($urandom_range(7));
      id_rd       = 5'($urandom_range(7));
      id_rd_we    = ($urandom_range(3) != 0);
      id_is_load  = ($urandom_range(2) == 0);
      id_is_mem   = ($urandom_range(2) == 0);
      id_is_br    = ($urandom_range(5) == 0);
      id_pred_tk  = 1'($urandom_range(1));
      mem_busy    = ($urandom_range(2) == 0);
      ex_br_valid = ($urandom_range(7) == 0);
      ex_br_taken = 1'($urandom_range(1));
      pc_freeze   = ($urandom_range(7) == 0);
      do_flush    = ($urandom_range(15) == 0);
      #1;
      model_eval();
      nchk++;
      if ({data, fwrd, str, ctrl, branch, crct, id_ready, br_err} !==
          {e_data, e_fwrd, e_str, e_ctrl, e_branch, e_crct, e_ready, m_err}) begin
        nfail++;
        $display("FAIL rand_outs cycle %0d got=%b exp=%b (data,fwrd,str,ctrl,branch,crct,ready,err)", k,
                 {data, fwrd, str, ctrl, branch, crct, id_ready, br_err},
                 {e_data, e_fwrd, e_str, e_ctrl, e_branch, e_crct, e_ready, m_err});
      end
      nchk++;
      if (flush_cnt !== 8'(m_flush) || stall_cnt !== 16'(m_stall)) begin
        nfail++;
        $display("FAIL rand_cnts cycle %0d got flush=%0d stall=%0d exp flush=%0d stall=%0d",
                 k, flush_cnt, stall_cnt, m_flush, m_stall);
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    model_reset();
    test_reset();
    test_load_use();
    test_alu_fwd();
    test_branch();
    test_struct();
    test_timeout();
    test_flush_sat();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
